// File: rtl/VX_cache_pkg.sv
// Shared cache types and default geometry for the per-bank memory request queue.
package VX_cache_pkg;

    localparam int unsigned CS_LINE_SIZE       = 16;
    localparam int unsigned CS_MREQ_SIZE       = 4;
    localparam int unsigned CS_MSHR_SIZE       = 4;
    localparam int unsigned CS_LINE_ADDR_WIDTH = 32 - $clog2(CS_LINE_SIZE);
    localparam int unsigned CS_MSHR_ID_W       = $clog2(CS_MSHR_SIZE);
    localparam int unsigned MREQ_PTR_W         = $clog2(CS_MREQ_SIZE) + 1;

    typedef struct packed {
        logic [CS_LINE_ADDR_WIDTH-1:0] addr;
        logic                          rw;
        logic [CS_LINE_SIZE-1:0]       byteen;
        logic [CS_LINE_SIZE*8-1:0]     data;
        logic [CS_MSHR_ID_W-1:0]       tag;
    } mreq_entry_t;

endpackage

// File: rtl/vx_cache_mreq_match.sv
// Per-entry comparator array: flags any valid queued writeback whose line address
// equals the lookup address.
module vx_cache_mreq_match #(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned ADDR_WIDTH  = 28
) (
    input  logic [NUM_ENTRIES-1:0]            valid,
    input  logic [NUM_ENTRIES-1:0]            rw,
    input  logic [NUM_ENTRIES*ADDR_WIDTH-1:0] addr,
    input  logic [ADDR_WIDTH-1:0]             lookup_addr,
    output logic                              pending
);

    logic [NUM_ENTRIES-1:0] hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            hit[i] = valid[i] & rw[i]
                   & (addr[i*ADDR_WIDTH +: ADDR_WIDTH] == lookup_addr);
        end
    end

    assign pending = |hit;

endmodule

// File: rtl/vx_cache_mreq_queue.sv
// Per-bank FIFO of fill reads and dirty writebacks toward memory.
// Define VX_CACHE_MREQ_COALESCE_EN to merge same-line writes into the tail entry.
module vx_cache_mreq_queue
    import VX_cache_pkg::*;
#(
    parameter int unsigned LINE_SIZE          = CS_LINE_SIZE,
    parameter int unsigned MREQ_SIZE          = CS_MREQ_SIZE,
    parameter int unsigned MSHR_SIZE          = CS_MSHR_SIZE,
    parameter int unsigned ALM_FULL_MARGIN    = 2,
    parameter int unsigned CS_LINE_ADDR_WIDTH = VX_cache_pkg::CS_LINE_ADDR_WIDTH,
    localparam int unsigned IDX_W             = $clog2(MREQ_SIZE),
    localparam int unsigned PTR_W             = IDX_W + 1,
    localparam int unsigned TAG_W             = $clog2(MSHR_SIZE)
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          enq_valid,
    input  logic [CS_LINE_ADDR_WIDTH-1:0] enq_addr,
    input  logic                          enq_rw,
    input  logic [LINE_SIZE-1:0]          enq_byteen,
    input  logic [LINE_SIZE*8-1:0]        enq_data,
    input  logic [TAG_W-1:0]              enq_id,
    output logic                          enq_ready,
    output logic                          enq_almost_full,

    output logic                          mem_req_valid,
    output logic [CS_LINE_ADDR_WIDTH-1:0] mem_req_addr,
    output logic                          mem_req_rw,
    output logic [LINE_SIZE-1:0]          mem_req_byteen,
    output logic [LINE_SIZE*8-1:0]        mem_req_data,
    output logic [TAG_W-1:0]              mem_req_tag,
    input  logic                          mem_req_ready,

    input  logic [CS_LINE_ADDR_WIDTH-1:0] lookup_addr,
    output logic                          lookup_pending,

    output logic [PTR_W-1:0]              count
);

    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [MREQ_SIZE-1:0] valid_q, valid_d;
    mreq_entry_t          mem_q [MREQ_SIZE];

    logic [IDX_W-1:0] rd_idx, wr_idx, tail_idx;
    logic             empty, full, pop, merge_ok, enq_fire, alloc;
    mreq_entry_t      head, tail, new_entry, merged_entry;

    assign rd_idx   = rd_ptr_q[IDX_W-1:0];
    assign wr_idx   = wr_ptr_q[IDX_W-1:0];
    assign tail_idx = wr_idx - IDX_W'(1);
    assign head     = mem_q[rd_idx];
    assign tail     = mem_q[tail_idx];

    assign empty = (rd_ptr_q == wr_ptr_q);
    assign full  = (rd_idx == wr_idx) && (rd_ptr_q[IDX_W] != wr_ptr_q[IDX_W]);
    assign pop   = ~empty & mem_req_ready;

`ifdef VX_CACHE_MREQ_COALESCE_EN
    // A single-entry queue whose head is leaving cannot absorb a merge.
    assign merge_ok = enq_valid & enq_rw & valid_q[tail_idx] & tail.rw
                    & (tail.addr == enq_addr) & ~(pop & (tail_idx == rd_idx));
`else
    assign merge_ok = 1'b0;
`endif

    assign enq_ready = ~full | merge_ok;
    assign enq_fire  = enq_valid & enq_ready;
    assign alloc     = enq_fire & ~merge_ok;

    always_comb begin
        new_entry        = '0;
        new_entry.addr   = enq_addr;
        new_entry.rw     = enq_rw;
        new_entry.byteen = enq_rw ? enq_byteen : '0;
        new_entry.data   = enq_rw ? enq_data : '0;
        new_entry.tag    = enq_rw ? '0 : enq_id;

        merged_entry        = tail;
        merged_entry.byteen = tail.byteen | enq_byteen;
        for (int b = 0; b < LINE_SIZE; b++) begin
            if (enq_byteen[b]) merged_entry.data[b*8 +: 8] = enq_data[b*8 +: 8];
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(alloc);
        valid_d  = valid_q;
        if (pop)   valid_d[rd_idx] = 1'b0;
        if (alloc) valid_d[wr_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            valid_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            valid_q  <= valid_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by pointers and valid_q.
    always_ff @(posedge clk) begin
        if (alloc) begin
            mem_q[wr_idx] <= new_entry;
        end else if (enq_fire && merge_ok) begin
            mem_q[tail_idx] <= merged_entry;
        end
    end

    assign mem_req_valid  = ~empty;
    assign mem_req_addr   = head.addr;
    assign mem_req_rw     = head.rw;
    assign mem_req_byteen = head.byteen;
    assign mem_req_data   = head.data;
    assign mem_req_tag    = head.tag;

    assign count           = wr_ptr_q - rd_ptr_q;
    assign enq_almost_full = (count >= PTR_W'(MREQ_SIZE - ALM_FULL_MARGIN));

    logic [MREQ_SIZE-1:0]                    ent_rw;
    logic [MREQ_SIZE*CS_LINE_ADDR_WIDTH-1:0] ent_addr;

    always_comb begin
        ent_rw   = '0;
        ent_addr = '0;
        for (int i = 0; i < MREQ_SIZE; i++) begin
            ent_rw[i] = mem_q[i].rw;
            ent_addr[i*CS_LINE_ADDR_WIDTH +: CS_LINE_ADDR_WIDTH] = mem_q[i].addr;
        end
    end

    vx_cache_mreq_match #(
        .NUM_ENTRIES (MREQ_SIZE),
        .ADDR_WIDTH  (CS_LINE_ADDR_WIDTH)
    ) u_match (
        .valid       (valid_q),
        .rw          (ent_rw),
        .addr        (ent_addr),
        .lookup_addr (lookup_addr),
        .pending     (lookup_pending)
    );

endmodule

// File: tb/tb_vx_cache_mreq_queue.sv
// Directed self-checking bench for vx_cache_mreq_queue; expectations follow
// VX_CACHE_MREQ_COALESCE_EN when it is defined.
module tb_vx_cache_mreq_queue;

    localparam int unsigned AW = 28;

    logic            clk = 1'b0;
    logic            reset;
    logic            enq_valid;
    logic [AW-1:0]   enq_addr;
    logic            enq_rw;
    logic [15:0]     enq_byteen;
    logic [127:0]    enq_data;
    logic [1:0]      enq_id;
    logic            enq_ready;
    logic            enq_almost_full;
    logic            mem_req_valid;
    logic [AW-1:0]   mem_req_addr;
    logic            mem_req_rw;
    logic [15:0]     mem_req_byteen;
    logic [127:0]    mem_req_data;
    logic [1:0]      mem_req_tag;
    logic            mem_req_ready;
    logic [AW-1:0]   lookup_addr;
    logic            lookup_pending;
    logic [2:0]      count;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] D1     = {16{8'h11}};
    localparam logic [127:0] D2     = {16{8'h22}};
    localparam logic [127:0] DMERGE = 128'h11111111_11111111_22222222_11111111;

    vx_cache_mreq_queue dut (
        .clk             (clk),
        .reset           (reset),
        .enq_valid       (enq_valid),
        .enq_addr        (enq_addr),
        .enq_rw          (enq_rw),
        .enq_byteen      (enq_byteen),
        .enq_data        (enq_data),
        .enq_id          (enq_id),
        .enq_ready       (enq_ready),
        .enq_almost_full (enq_almost_full),
        .mem_req_valid   (mem_req_valid),
        .mem_req_addr    (mem_req_addr),
        .mem_req_rw      (mem_req_rw),
        .mem_req_byteen  (mem_req_byteen),
        .mem_req_data    (mem_req_data),
        .mem_req_tag     (mem_req_tag),
        .mem_req_ready   (mem_req_ready),
        .lookup_addr     (lookup_addr),
        .lookup_pending  (lookup_pending),
        .count           (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_enq(input logic v, input logic rw, input logic [AW-1:0] a,
                           input logic [15:0] be, input logic [127:0] d, input logic [1:0] id);
        enq_valid  = v;
        enq_rw     = rw;
        enq_addr   = a;
        enq_byteen = be;
        enq_data   = d;
        enq_id     = id;
    endtask

    initial begin
        reset         = 1'b0;
        mem_req_ready = 1'b0;
        lookup_addr   = '0;
        set_enq(1'b0, 1'b0, '0, '0, '0, 2'd0);
        tick();
        tick();
        reset = 1'b1;
        check_eq("rst_count", 128'(count), 128'd0);
        check_eq("rst_valid", 128'(mem_req_valid), 128'd0);
        check_eq("rst_ready", 128'(enq_ready), 128'd1);
        check_eq("rst_afull", 128'(enq_almost_full), 128'd0);
        check_eq("rst_pending", 128'(lookup_pending), 128'd0);

        // Reset mid-traffic
        for (int i = 0; i < 3; i++) begin
            set_enq(1'b1, 1'b0, AW'(i + 1), '0, '0, 2'(i));
            tick();
        end
        set_enq(1'b0, 1'b0, '0, '0, '0, 2'd0);
        check_eq("mid_count3", 128'(count), 128'd3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_eq("mid_rst_count", 128'(count), 128'd0);
        check_eq("mid_rst_valid", 128'(mem_req_valid), 128'd0);
        check_eq("mid_rst_ready", 128'(enq_ready), 128'd1);

        // Fill to full
        for (int i = 0; i < 4; i++) begin
            set_enq(1'b1, 1'b0, AW'(16 + i), '0, '0, 2'(i));
            tick();
            check_eq($sformatf("fill_count%0d", i), 128'(count), 128'(i + 1));
            check_eq($sformatf("fill_afull%0d", i), 128'(enq_almost_full),
                     128'((i + 1) >= 2));
        end
        check_eq("full_ready", 128'(enq_ready), 128'd0);
        check_eq("full_head_tag", 128'(mem_req_tag), 128'd0);

        // Full with simultaneous enq/pop: only the pop happens
        set_enq(1'b1, 1'b0, AW'('h99), '0, '0, 2'd3);
        mem_req_ready = 1'b1;
        #1;
        check_eq("full_simul_ready", 128'(enq_ready), 128'd0);
        tick();
        check_eq("full_simul_count", 128'(count), 128'd3);
        check_eq("full_simul_tag", 128'(mem_req_tag), 128'd1);
        check_eq("full_simul_ready_after", 128'(enq_ready), 128'd1);
        mem_req_ready = 1'b0;
        tick();
        check_eq("refill_count", 128'(count), 128'd4);
        set_enq(1'b0, 1'b0, '0, '0, '0, 2'd0);
        mem_req_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            check_eq($sformatf("drain_tag%0d", i), 128'(mem_req_tag), 128'(i));
            tick();
        end
        check_eq("drain_last_tag", 128'(mem_req_tag), 128'd3);
        check_eq("drain_last_addr", 128'(mem_req_addr), 128'h99);
        tick();
        check_eq("drain_count", 128'(count), 128'd0);
        check_eq("drain_valid", 128'(mem_req_valid), 128'd0);

        // 1-entry queue with simultaneous enq/pop
        mem_req_ready = 1'b0;
        set_enq(1'b1, 1'b0, AW'('h30), '0, '0, 2'd1);
        tick();
        check_eq("one_tag", 128'(mem_req_tag), 128'd1);
        set_enq(1'b1, 1'b0, AW'('h31), '0, '0, 2'd2);
        mem_req_ready = 1'b1;
        tick();
        set_enq(1'b0, 1'b0, '0, '0, '0, 2'd0);
        check_eq("one_simul_count", 128'(count), 128'd1);
        check_eq("one_simul_tag", 128'(mem_req_tag), 128'd2);
        check_eq("one_simul_valid", 128'(mem_req_valid), 128'd1);
        tick();
        check_eq("one_drain_count", 128'(count), 128'd0);

        // Lookup of a queued writeback
        mem_req_ready = 1'b0;
        lookup_addr   = AW'('h40);
        set_enq(1'b1, 1'b1, AW'('h40), 16'h000F, D1, 2'd3);
        #1;
        check_eq("lk_enq_cycle", 128'(lookup_pending), 128'd0);
        tick();
        set_enq(1'b0, 1'b0, '0, '0, '0, 2'd0);
        check_eq("lk_after", 128'(lookup_pending), 128'd1);
        check_eq("lk_head_rw", 128'(mem_req_rw), 128'd1);
        check_eq("lk_head_tag", 128'(mem_req_tag), 128'd0);
        mem_req_ready = 1'b1;
        #1;
        check_eq("lk_pop_cycle", 128'(lookup_pending), 128'd1);
        tick();
        check_eq("lk_dropped", 128'(lookup_pending), 128'd0);
        check_eq("lk_count", 128'(count), 128'd0);

        // Two writes to the same line
        mem_req_ready = 1'b0;
        set_enq(1'b1, 1'b1, AW'('h40), 16'h000F, D1, 2'd0);
        tick();
        set_enq(1'b1, 1'b1, AW'('h40), 16'h00F0, D2, 2'd0);
        tick();
        set_enq(1'b0, 1'b0, '0, '0, '0, 2'd0);
`ifdef VX_CACHE_MREQ_COALESCE_EN
        check_eq("co_count", 128'(count), 128'd1);
        check_eq("co_byteen", 128'(mem_req_byteen), 128'h00FF);
        check_eq("co_data", mem_req_data, DMERGE);
        mem_req_ready = 1'b1;
        tick();
        check_eq("co_drain", 128'(count), 128'd0);
`else
        check_eq("nc_count", 128'(count), 128'd2);
        check_eq("nc_byteen0", 128'(mem_req_byteen), 128'h000F);
        check_eq("nc_data0", mem_req_data, D1);
        mem_req_ready = 1'b1;
        tick();
        check_eq("nc_byteen1", 128'(mem_req_byteen), 128'h00F0);
        check_eq("nc_data1", mem_req_data, D2);
        tick();
        check_eq("nc_drain", 128'(count), 128'd0);
`endif
        mem_req_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
